// File: rtl/vga_frame_reader.sv
// 640x480@60 VGA scan-out of a framebuffer stored as 192-bit words of six 32-bit ARGB pixels.
// Optional macro VGA_ALPHA_BLEND_EN blends image pixels against BG using the lane alpha.
module vga_frame_reader #(
  parameter int          V         = 192,
  parameter int          S         = 32,
  parameter int          AW        = 15,
  parameter int          BASE_ADDR = 0,
  parameter int          IMG_W     = 120,
  parameter int          IMG_H     = 120,
  parameter int          X0        = 0,
  parameter int          Y0        = 0,
  parameter logic [23:0] BG        = 24'h000000
) (
  input  logic          clk,
  input  logic          rst,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [V-1:0]  rd_data,
  output logic [23:0]   rgb,
  output logic          h_sync,
  output logic          v_sync,
  output logic          vga_clk,
  output logic          vblank
);

  localparam logic [9:0]    H_LAST = 10'd799;
  localparam logic [9:0]    V_LAST = 10'd524;
  localparam logic [9:0]    X_LO   = 10'(X0);
  localparam logic [9:0]    Y_LO   = 10'(Y0);
  localparam logic [9:0]    W10    = 10'(IMG_W);
  localparam logic [9:0]    H10    = 10'(IMG_H);
  localparam logic [9:0]    W_LAST = 10'(IMG_W - 6);
  localparam logic [AW-1:0] BASE   = AW'(BASE_ADDR);
  localparam logic [AW-1:0] WPL    = AW'(IMG_W / 6);
`ifdef VGA_ALPHA_BLEND_EN
  localparam int PW = 32;
`else
  localparam int PW = 24;
`endif

  logic          pix_en;
  logic [9:0]    h_cnt, v_cnt;
  logic [2:0]    lane;
  logic [AW-1:0] row_ptr;
  logic [V-1:0]  cur_word, nxt_word;
  logic          rd_vld, armed;

  logic [9:0]    x_off, y_off, y_next, yn_off;
  logic          active, in_win, nxt_in_win, preload, fetch;
  logic [AW-1:0] row_nxt;
  logic [V-1:0]  sel_word;
  logic [PW-1:0] pix;
  logic [23:0]   win_rgb;

  function automatic logic [S-1:0] lane_of(input logic [V-1:0] word, input logic [2:0] k);
    case (k)
      3'd1:    lane_of = word[2*S-1:S];
      3'd2:    lane_of = word[3*S-1:2*S];
      3'd3:    lane_of = word[4*S-1:3*S];
      3'd4:    lane_of = word[5*S-1:4*S];
      3'd5:    lane_of = word[6*S-1:5*S];
      default: lane_of = word[S-1:0];
    endcase
  endfunction

  // Window decode and read-event detection from the current scan position.
  always_comb begin
    // Offsets wrap to large values left/above the window, so one unsigned compare bounds both sides.
    x_off      = h_cnt - X_LO;
    y_off      = v_cnt - Y_LO;
    y_next     = (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
    yn_off     = y_next - Y_LO;
    active     = (h_cnt < 10'd640) && (v_cnt < 10'd480);
    in_win     = (x_off < W10) && (y_off < H10);
    nxt_in_win = (yn_off < H10);
    preload    = (h_cnt == 10'd640) && nxt_in_win;
    fetch      = in_win && (lane == 3'd0) && armed && (x_off < W_LAST);
    row_nxt    = (nxt_in_win && (yn_off != 10'd0)) ? row_ptr + WPL : BASE;
    sel_word   = (lane == 3'd0) ? nxt_word : cur_word;
    pix        = PW'(lane_of(sel_word, lane));
  end

`ifdef VGA_ALPHA_BLEND_EN
  function automatic logic [7:0] blend(input logic [7:0] c, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] sum;
    sum   = ({8'd0, c} * {8'd0, a}) + ({8'd0, b} * {8'd0, 8'd255 - a});
    blend = sum[15:8];
  endfunction

  assign win_rgb = {blend(pix[23:16], pix[31:24], BG[23:16]),
                    blend(pix[15:8],  pix[31:24], BG[15:8]),
                    blend(pix[7:0],   pix[31:24], BG[7:0])};
`else
  assign win_rgb = pix[23:0];
`endif

  // Timing counters, word buffering, read strobes and registered video outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pix_en   <= 1'b0;
      vga_clk  <= 1'b0;
      h_cnt    <= 10'd0;
      v_cnt    <= 10'd0;
      lane     <= 3'd0;
      row_ptr  <= BASE;
      cur_word <= '0;
      nxt_word <= '0;
      rd_vld   <= 1'b0;
      armed    <= 1'b0;
      rd_en    <= 1'b0;
      rd_addr  <= '0;
      rgb      <= 24'h000000;
      h_sync   <= 1'b1;
      v_sync   <= 1'b1;
      vblank   <= 1'b0;
    end else begin
      pix_en  <= ~pix_en;
      vga_clk <= ~pix_en;
      rd_en   <= 1'b0;
      rd_vld  <= rd_en;
      if (rd_vld) nxt_word <= rd_data;
      if (pix_en) begin
        h_cnt <= (h_cnt == H_LAST) ? 10'd0 : h_cnt + 10'd1;
        if (h_cnt == H_LAST) v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
        rgb    <= in_win ? win_rgb : (active ? BG : 24'h000000);
        h_sync <= ~((h_cnt >= 10'd656) && (h_cnt <= 10'd751));
        v_sync <= ~((v_cnt >= 10'd490) && (v_cnt <= 10'd491));
        vblank <= (v_cnt >= 10'd480);
        if (in_win) lane <= (lane == 3'd5) ? 3'd0 : lane + 3'd1;
        if (in_win && (lane == 3'd0)) cur_word <= nxt_word;
        // A line only fetches in-line words if its first word was preloaded.
        if (h_cnt == 10'd640) begin
          armed   <= nxt_in_win;
          row_ptr <= row_nxt;
        end
        if (preload) begin
          rd_en   <= 1'b1;
          rd_addr <= row_nxt;
        end else if (fetch) begin
          rd_en   <= 1'b1;
          rd_addr <= rd_addr + AW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_frame_reader.sv
// Self-checking bench for vga_frame_reader: scan-position model checked every clock plus literal spot checks.
module tb_vga_frame_reader;
  localparam int          V         = 192;
  localparam int          S         = 32;
  localparam int          AW        = 15;
  localparam int          BASE_ADDR = 5;
  localparam int          IMG_W     = 120;
  localparam int          IMG_H     = 4;
  localparam int          X0        = 6;
  localparam int          Y0        = 2;
  localparam logic [23:0] BG        = 24'h0000FF;
  localparam int          WPL       = IMG_W / 6;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [V-1:0]  rd_data;
  logic [23:0]   rgb;
  logic          h_sync, v_sync, vga_clk, vblank;

  int total = 0;
  int bad   = 0;
  int k     = 0;
  int run_id = 1;
  logic [23:0] rgb_log [0:6399];
  int rd_per_line [0:7];
  int hs_low_line0 = 0;
  int pre_addr = -1;
  int fetch_addr_l3 = -1;

  vga_frame_reader #(
    .V(V), .S(S), .AW(AW), .BASE_ADDR(BASE_ADDR), .IMG_W(IMG_W), .IMG_H(IMG_H),
    .X0(X0), .Y0(Y0), .BG(BG)
  ) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .rgb(rgb), .h_sync(h_sync), .v_sync(v_sync), .vga_clk(vga_clk), .vblank(vblank)
  );

  always #10 clk = ~clk;

  function automatic logic [V-1:0] ram_word(input int a);
    logic [V-1:0] w;
    for (int j = 0; j < 6; j++) w[j*32 +: 32] = {8'hA5, 24'(a*6 + j)};
    return w;
  endfunction

  // RAM: data valid only in the clock right after the strobe, garbage otherwise
  always @(posedge clk) rd_data <= rd_en ? ram_word(int'(rd_addr)) : {6{32'hDEADBEEF}};

  always @(posedge clk or negedge rst)
    if (!rst) k <= 0;
    else      k <= k + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (k=%0d run=%0d)", name, act, exp, k, run_id);
    end
  endtask

  function automatic logic [23:0] exp_rgb(input int h, input int v);
    int xo, yo;
    xo = h - X0;
    yo = v - Y0;
    if (h >= 640 || v >= 480) return 24'h000000;
    if (xo < 0 || xo >= IMG_W || yo < 0 || yo >= IMG_H) return BG;
    return 24'((BASE_ADDR + yo*WPL + xo/6) * 6 + xo % 6);
  endfunction

  // Address of the read issued while displaying (h,v), or -1 if none.
  function automatic int exp_rd(input int h, input int v);
    int yn, xo, yo;
    yn = (v == 524) ? 0 : v + 1;
    if (h == 640) return (yn >= Y0 && yn < Y0 + IMG_H) ? BASE_ADDR + (yn - Y0)*WPL : -1;
    xo = h - X0;
    yo = v - Y0;
    if (h < 640 && xo >= 0 && xo < IMG_W && yo >= 0 && yo < IMG_H && xo % 6 == 0 && xo/6 < WPL - 1)
      return BASE_ADDR + yo*WPL + xo/6 + 1;
    return -1;
  endfunction

  always @(negedge clk) begin
    int p, h, v, ea;
    if (k < 2) begin
      check("rgb_rst", rgb, 24'h000000);
      check("hsync_rst", h_sync, 1'b1);
      check("vsync_rst", v_sync, 1'b1);
      check("vblank_rst", vblank, 1'b0);
      check("rd_en_rst", rd_en, 1'b0);
      check("rd_addr_rst", rd_addr, 15'd0);
      check("vga_clk_rst", vga_clk, (k == 1) ? 1'b1 : 1'b0);
    end else begin
      p = k/2 - 1;
      h = p % 800;
      v = (p / 800) % 525;
      check("vga_clk", vga_clk, (k % 2 == 1) ? 1'b1 : 1'b0);
      check("rgb", rgb, exp_rgb(h, v));
      check("h_sync", h_sync, (h >= 656 && h <= 751) ? 1'b0 : 1'b1);
      check("v_sync", v_sync, (v >= 490 && v <= 491) ? 1'b0 : 1'b1);
      check("vblank", vblank, (v >= 480) ? 1'b1 : 1'b0);
      ea = (k % 2 == 0) ? exp_rd(h, v) : -1;
      check("rd_en", rd_en, (ea >= 0) ? 1'b1 : 1'b0);
      if (ea >= 0) check("rd_addr", rd_addr, ea);
      if (run_id == 2 && k % 2 == 0 && p < 6400) begin
        rgb_log[p] <= rgb;
        if (rd_en) rd_per_line[v] <= rd_per_line[v] + 1;
        if (v == 0 && !h_sync) hs_low_line0 <= hs_low_line0 + 1;
        if (rd_en && h == 640 && v == 1) pre_addr <= int'(rd_addr);
        if (rd_en && h == 6 && v == 3) fetch_addr_l3 <= int'(rd_addr);
      end
    end
  end

  initial begin
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #3 rst = 1'b1;
    // stop with the counters at h=300, v=5
    repeat (2*(5*800 + 300)) @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("async_rgb", rgb, 24'h000000);
    check("async_rd_en", rd_en, 1'b0);
    check("async_vga_clk", vga_clk, 1'b0);
    check("async_hsync", h_sync, 1'b1);
    run_id = 2;
    repeat (10) @(posedge clk);
    #3 rst = 1'b1;
    repeat (2*6400 + 4) @(posedge clk);
    @(negedge clk);
    check("px_6_2", rgb_log[2*800 + 6], 24'h00001E);
    check("px_13_2", rgb_log[2*800 + 13], 24'h000025);
    check("px_125_2", rgb_log[2*800 + 125], 24'h000095);
    check("px_6_3", rgb_log[3*800 + 6], 24'h000096);
    check("px_5_2_bg", rgb_log[2*800 + 5], 24'h0000FF);
    check("px_6_1_bg", rgb_log[1*800 + 6], 24'h0000FF);
    check("px_126_2_bg", rgb_log[2*800 + 126], 24'h0000FF);
    check("px_6_6_bg", rgb_log[6*800 + 6], 24'h0000FF);
    check("px_700_2_blank", rgb_log[2*800 + 700], 24'h000000);
    check("reads_line0", rd_per_line[0], 0);
    check("reads_line1", rd_per_line[1], 1);
    check("reads_line2", rd_per_line[2], 20);
    check("reads_line5", rd_per_line[5], 19);
    check("reads_line6", rd_per_line[6], 0);
    check("hsync_low_len", hs_low_line0, 96);
    check("preload_addr", pre_addr, 5);
    check("fetch_addr_l3", fetch_addr_l3, 26);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
